id_lexer: RTL

Streaming character classifier and tokenizer; the parametrised successor of the single-bit identifier recogniser. Consumes one 8-bit ASCII character per accepted cycle, splits the stream on delimiters and classifies each token as identifier, decimal number or error. For each token it emits a one-cycle token record with length, and it keeps saturating per-class counters. Sits between the character source (UART/testbench stream) and downstream parsing logic.

---
 rtl/id_lexer_pkg.sv | 63 ++++++
 rtl/id_lexer_if.sv | 26 ++
 rtl/id_lexer_char_class.sv | 25 ++
 rtl/id_lexer.sv | 118 +++++++++++
 4 files changed

// File: rtl/id_lexer_pkg.sv
// Shared types for the identifier lexer: character classes, token codes,
// lexer states and the ASCII constants used by the classifier.
package id_lexer_pkg;

    typedef enum logic [1:0] {
        CC_ALPHA = 2'd0,
        CC_DIGIT = 2'd1,
        CC_DELIM = 2'd2,
        CC_OTHER = 2'd3
    } char_class_e;

    typedef enum logic [1:0] {
        TOK_NONE   = 2'd0,
        TOK_IDENT  = 2'd1,
        TOK_NUMBER = 2'd2,
        TOK_ERROR  = 2'd3
    } tok_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IDENT = 2'd1,
        ST_NUM   = 2'd2,
        ST_BAD   = 2'd3
    } lex_state_e;

    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_TAB        = 8'h09;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_COMMA      = 8'h2C;
    localparam logic [7:0] ASCII_SEMI       = 8'h3B;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;
    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_9          = 8'h39;
    localparam logic [7:0] ASCII_UC_A       = 8'h41;
    localparam logic [7:0] ASCII_UC_Z       = 8'h5A;
    localparam logic [7:0] ASCII_LC_A       = 8'h61;
    localparam logic [7:0] ASCII_LC_Z       = 8'h7A;

    // Transition on a non-delimiter character; delimiters are handled by the caller.
    function automatic lex_state_e step_state(lex_state_e st, char_class_e cc);
        lex_state_e nxt;
        nxt = ST_BAD;
        case (st)
            ST_IDLE:  nxt = (cc == CC_ALPHA) ? ST_IDENT :
                            (cc == CC_DIGIT) ? ST_NUM : ST_BAD;
            ST_IDENT: nxt = (cc == CC_ALPHA || cc == CC_DIGIT) ? ST_IDENT : ST_BAD;
            ST_NUM:   nxt = (cc == CC_DIGIT) ? ST_NUM : ST_BAD;
            default:  nxt = ST_BAD;
        endcase
        return nxt;
    endfunction

    function automatic tok_type_e tok_of(lex_state_e st, logic ovf);
        tok_type_e t;
        t = TOK_NONE;
        if (st == ST_BAD || (st != ST_IDLE && ovf)) t = TOK_ERROR;
        else if (st == ST_IDENT)                     t = TOK_IDENT;
        else if (st == ST_NUM)                       t = TOK_NUMBER;
        return t;
    endfunction

endpackage

// File: rtl/id_lexer_if.sv
// Character stream in, token records and counters out.
interface id_lexer_if #(
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_char;
    logic             in_last;
    logic             tok_valid;
    logic [1:0]       tok_type;
    logic [LEN_W-1:0] tok_len;
    logic             match;
    logic [CNT_W-1:0] id_cnt;
    logic [CNT_W-1:0] num_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_char, in_last,
        input  tok_valid, tok_type, tok_len, match, id_cnt, num_cnt, err_cnt
    );

    modport slave (
        input  in_valid, in_char, in_last,
        output tok_valid, tok_type, tok_len, match, id_cnt, num_cnt, err_cnt
    );
endinterface

// File: rtl/id_lexer_char_class.sv
// Combinational ASCII classifier: ALPHA / DIGIT / DELIM / OTHER.
module char_class
    import id_lexer_pkg::*;
#(
    parameter bit ALLOW_UNDERSCORE = 1'b1
) (
    input  logic [7:0]  ch,
    output char_class_e cls
);

    always_comb begin
        cls = CC_OTHER;
        if ((ch >= ASCII_UC_A && ch <= ASCII_UC_Z) ||
            (ch >= ASCII_LC_A && ch <= ASCII_LC_Z) ||
            (ALLOW_UNDERSCORE && ch == ASCII_UNDERSCORE)) begin
            cls = CC_ALPHA;
        end else if (ch >= ASCII_0 && ch <= ASCII_9) begin
            cls = CC_DIGIT;
        end else if (ch == ASCII_SPACE || ch == ASCII_TAB || ch == ASCII_LF ||
                     ch == ASCII_CR || ch == ASCII_COMMA || ch == ASCII_SEMI) begin
            cls = CC_DELIM;
        end
    end

endmodule

// File: rtl/id_lexer.sv
// Streaming tokenizer: splits characters on delimiters, emits one-cycle
// token records (IDENT / NUMBER / ERROR) and keeps saturating per-class counts.
//
//   state    | meaning
//   ST_IDLE  | no open token
//   ST_IDENT | open token is letters/digits starting with a letter
//   ST_NUM   | open token is digits only
//   ST_BAD   | open token contains an illegal sequence
module id_lexer
    import id_lexer_pkg::*;
#(
    parameter int MAX_LEN          = 16,
    parameter int CNT_W            = 8,
    parameter bit ALLOW_UNDERSCORE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    id_lexer_if.slave   bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    lex_state_e       state, state_nxt, cons_state;
    char_class_e      cls;
    logic             is_delim, emit;
    logic [LEN_W-1:0] len_q, len_nxt, cons_len;
    logic             ovf_q, ovf_nxt, cons_ovf;
    tok_type_e        emit_type;

    logic             tok_valid_q;
    tok_type_e        tok_type_q;
    logic [LEN_W-1:0] tok_len_q;
    logic             match_q;
    logic [CNT_W-1:0] id_cnt_q, num_cnt_q, err_cnt_q;

    char_class #(.ALLOW_UNDERSCORE(ALLOW_UNDERSCORE)) u_class (
        .ch  (bus.in_char),
        .cls (cls)
    );

    assign is_delim = (cls == CC_DELIM);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // cons_state is the state after the character is absorbed, before any close.
    always_comb begin
        cons_state = state;
        if (!is_delim) cons_state = step_state(state, cls);
        emit = bus.in_valid && (cons_state != ST_IDLE) && (is_delim || bus.in_last);
        state_nxt = state;
        if (bus.in_valid) state_nxt = emit ? ST_IDLE : cons_state;
    end

    always_comb begin
        cons_len = len_q;
        cons_ovf = ovf_q;
        if (!is_delim) begin
            if (state == ST_IDLE) begin
                cons_len = LEN_W'(1);
                cons_ovf = 1'b0;
            end else if (len_q == LEN_MAX) begin
                cons_ovf = 1'b1;
            end else begin
                cons_len = len_q + 1'b1;
            end
        end
        emit_type = tok_of(cons_state, cons_ovf);
        len_nxt   = len_q;
        ovf_nxt   = ovf_q;
        if (bus.in_valid) begin
            len_nxt = emit ? '0   : cons_len;
            ovf_nxt = emit ? 1'b0 : cons_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            ovf_q       <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= TOK_NONE;
            tok_len_q   <= '0;
            match_q     <= 1'b0;
            id_cnt_q    <= '0;
            num_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            len_q       <= len_nxt;
            ovf_q       <= ovf_nxt;
            tok_valid_q <= emit;
            match_q     <= (state_nxt == ST_IDENT) && !ovf_nxt;
            if (emit) begin
                tok_type_q <= emit_type;
                tok_len_q  <= cons_len;
                case (emit_type)
                    TOK_IDENT:  if (id_cnt_q  != CNT_SAT) id_cnt_q  <= id_cnt_q  + 1'b1;
                    TOK_NUMBER: if (num_cnt_q != CNT_SAT) num_cnt_q <= num_cnt_q + 1'b1;
                    TOK_ERROR:  if (err_cnt_q != CNT_SAT) err_cnt_q <= err_cnt_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_type  = tok_type_q;
    assign bus.tok_len   = tok_len_q;
    assign bus.match     = match_q;
    assign bus.id_cnt    = id_cnt_q;
    assign bus.num_cnt   = num_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
